// File: rtl/bus_rr_arbiter_ctrl.sv
// Round-robin arbiter/sequencer: pops one pending driver FIFO at a time and pushes the word
// to its decoded destination port(s). Optional broadcast delivery under `BUS_BCAST_EN`.
module bus_rr_arbiter_ctrl #(
    parameter int unsigned PCKG_SZ  = 16,
    parameter int unsigned DRVRS    = 8,
    parameter logic [7:0]  BCAST_ID = 8'hFF
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DRVRS-1:0]           pndng,
    input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
    output logic [DRVRS-1:0]           pop,
    output logic [DRVRS-1:0]           push,
    output logic [PCKG_SZ-1:0]         D_push,
    output logic [$clog2(DRVRS)-1:0]   gnt_id,
    output logic                       busy,
    output logic [15:0]                pkt_cnt,
    output logic [7:0]                 err_cnt
);

    localparam int unsigned IdW = $clog2(DRVRS);
    localparam logic [DRVRS-1:0] OneHot0 = DRVRS'(1);

    typedef enum logic [1:0] {StIdle, StPop, StPush} state_e;

    state_e             state_q;
    logic [IdW-1:0]     rr_ptr_q;
    logic [IdW-1:0]     gnt_q;
    logic [IdW-1:0]     win_idx;
    logic [PCKG_SZ-1:0] head;
    logic [PCKG_SZ-1:0] data_q;
    logic [7:0]         dest;
    logic [DRVRS-1:0]   pop_q;
    logic [DRVRS-1:0]   push_q;
    logic [DRVRS-1:0]   push_nxt;
    logic               deliver;
    logic               drop;
    logic               busy_q;
    logic [15:0]        pkt_q;
    logic [7:0]         err_q;
    int unsigned        sidx;

    // Scan downward so the lowest offset from rr_ptr is the last (winning) assignment.
    always_comb begin
        win_idx = rr_ptr_q;
        sidx    = 0;
        for (int k = DRVRS - 1; k >= 0; k--) begin
            sidx = 32'(rr_ptr_q) + 32'(k);
            if (sidx >= DRVRS) begin
                sidx = sidx - DRVRS;
            end
            if (pndng[sidx[IdW-1:0]]) begin
                win_idx = sidx[IdW-1:0];
            end
        end
    end

    always_comb begin
        head = '0;
        for (int i = 0; i < DRVRS; i++) begin
            if (gnt_q == i[IdW-1:0]) begin
                head = D_pop[i*PCKG_SZ +: PCKG_SZ];
            end
        end
    end

    assign dest = head[PCKG_SZ-1 -: 8];

    // Destination decode is done on the FIFO head while popping so push is registered.
    always_comb begin
        push_nxt = '0;
        deliver  = 1'b0;
        drop     = 1'b0;
        if (dest == BCAST_ID) begin
`ifdef BUS_BCAST_EN
            push_nxt = ~(OneHot0 << gnt_q);
            deliver  = 1'b1;
`else
            drop     = 1'b1;
`endif
        end else if (32'(dest) >= DRVRS || dest == 8'(gnt_q)) begin
            drop = 1'b1;
        end else begin
            push_nxt = OneHot0 << dest;
            deliver  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            gnt_q    <= '0;
            data_q   <= '0;
            pop_q    <= '0;
            push_q   <= '0;
            busy_q   <= 1'b0;
            pkt_q    <= '0;
            err_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (|pndng) begin
                        state_q <= StPop;
                        gnt_q   <= win_idx;
                        pop_q   <= OneHot0 << win_idx;
                        busy_q  <= 1'b1;
                    end
                end
                StPop: begin
                    state_q  <= StPush;
                    pop_q    <= '0;
                    data_q   <= head;
                    push_q   <= push_nxt;
                    rr_ptr_q <= (gnt_q == IdW'(DRVRS - 1)) ? '0 : gnt_q + 1'b1;
                    if (deliver && pkt_q != 16'hFFFF) begin
                        pkt_q <= pkt_q + 16'd1;
                    end
                    if (drop && err_q != 8'hFF) begin
                        err_q <= err_q + 8'd1;
                    end
                end
                StPush: begin
                    state_q <= StIdle;
                    push_q  <= '0;
                    busy_q  <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign pop     = pop_q;
    assign push    = push_q;
    assign D_push  = data_q;
    assign gnt_id  = gnt_q;
    assign busy    = busy_q;
    assign pkt_cnt = pkt_q;
    assign err_cnt = err_q;

endmodule

// File: tb/tb_bus_rr_arbiter_ctrl.sv
// Self-checking bench for bus_rr_arbiter_ctrl: directed scenarios plus randomized traffic
// compared against a transaction-level round-robin model.
module tb_bus_rr_arbiter_ctrl;

    localparam int N = 8;
    localparam int W = 16;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   pndng = '0;
    logic [N*W-1:0] d_pop;
    logic [W-1:0]   head [N];
    logic [N-1:0]   pop;
    logic [N-1:0]   push;
    logic [W-1:0]   d_push;
    logic [2:0]     gnt_id;
    logic           busy;
    logic [15:0]    pkt_cnt;
    logic [7:0]     err_cnt;

    int unsigned n_chk = 0;
    int unsigned n_pass = 0;
    int          m_ptr = 0;
    int          m_pkt = 0;
    int          m_err = 0;

    bus_rr_arbiter_ctrl #(.PCKG_SZ(W), .DRVRS(N), .BCAST_ID(8'hFF)) dut (
        .clk     (clk),
        .reset   (reset),
        .pndng   (pndng),
        .D_pop   (d_pop),
        .pop     (pop),
        .push    (push),
        .D_push  (d_push),
        .gnt_id  (gnt_id),
        .busy    (busy),
        .pkt_cnt (pkt_cnt),
        .err_cnt (err_cnt)
    );

    always #5 clk = ~clk;

    always_comb begin
        d_pop = '0;
        for (int i = 0; i < N; i++) d_pop[i*W +: W] = head[i];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int pick(input logic [N-1:0] m, input int ptr);
        for (int k = 0; k < N; k++) begin
            if (m[(ptr + k) % N]) return (ptr + k) % N;
        end
        return -1;
    endfunction

    task automatic do_reset();
        reset = 1'b0;
        pndng = '0;
        @(posedge clk); #1;
        reset = 1'b1;
        m_ptr = 0;
        m_pkt = 0;
        m_err = 0;
    endtask

    // One arbitration slot: predict winner and delivery from the current pending set.
    task automatic run_txn();
        int         w;
        logic [7:0] dest;
        logic [7:0] exp_push;
        w = pick(pndng, m_ptr);
        @(posedge clk); #1;
        if (w < 0) begin
            check_eq("idle_pop", 32'(pop), 32'h0);
            check_eq("idle_busy", 32'(busy), 32'h0);
            return;
        end
        check_eq("pop", 32'(pop), 32'(1 << w));
        check_eq("gnt_id", 32'(gnt_id), 32'(w));
        check_eq("busy_pop", 32'(busy), 32'h1);
        dest = head[w][15:8];
        exp_push = '0;
        if (dest == 8'hFF) begin
`ifdef BUS_BCAST_EN
            exp_push = 8'hFF & ~(8'(1) << w);
            if (m_pkt < 65535) m_pkt++;
`else
            if (m_err < 255) m_err++;
`endif
        end else if (int'(dest) < N && int'(dest) != w) begin
            exp_push = 8'(1) << dest;
            if (m_pkt < 65535) m_pkt++;
        end else begin
            if (m_err < 255) m_err++;
        end
        @(posedge clk); #1;
        check_eq("push", 32'(push), 32'(exp_push));
        check_eq("d_push", 32'(d_push), 32'(head[w]));
        check_eq("pop_clr", 32'(pop), 32'h0);
        check_eq("pkt_cnt", 32'(pkt_cnt), 32'(m_pkt));
        check_eq("err_cnt", 32'(err_cnt), 32'(m_err));
        m_ptr = (w + 1) % N;
        pndng[w] = 1'b0;
        @(posedge clk); #1;
        check_eq("push_clr", 32'(push), 32'h0);
        check_eq("busy_idle", 32'(busy), 32'h0);
    endtask

    function automatic logic [15:0] rand_head(input int p);
        logic [7:0] d;
        case ($urandom_range(0, 3))
            0:       d = 8'($urandom_range(0, N - 1));
            1:       d = 8'(p);
            2:       d = 8'($urandom_range(N, 254));
            default: d = 8'hFF;
        endcase
        return {d, 8'($urandom)};
    endfunction

    initial begin
        for (int i = 0; i < N; i++) head[i] = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_pop", 32'(pop), 32'h0);
        check_eq("rst_push", 32'(push), 32'h0);
        check_eq("rst_d_push", 32'(d_push), 32'h0);
        check_eq("rst_gnt", 32'(gnt_id), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_pkt", 32'(pkt_cnt), 32'h0);
        check_eq("rst_err", 32'(err_cnt), 32'h0);
        reset = 1'b1;

        // Single request from port 2 to port 5.
        head[2] = 16'h05AB;
        pndng = 8'h04;
        run_txn();
        check_eq("single_pkt", 32'(pkt_cnt), 32'h1);

        // Fairness from reset: all ports pending.
        do_reset();
        for (int i = 0; i < N; i++) head[i] = {8'((i + 1) % N), 8'(i)};
        pndng = '1;
        for (int i = 0; i < N; i++) begin
            run_txn();
            check_eq("fair_gnt", 32'(gnt_id), 32'(i));
        end
        check_eq("fair_pkt", 32'(pkt_cnt), 32'(N));

        // Wrap after last grant 7.
        head[0] = 16'h0300;
        head[6] = 16'h0100;
        pndng = 8'h41;
        run_txn();
        check_eq("wrap_first", 32'(gnt_id), 32'h0);
        run_txn();
        check_eq("wrap_second", 32'(gnt_id), 32'h6);

        // Invalid destination, then loopback.
        do_reset();
        head[1] = 16'h0A00;
        pndng = 8'h02;
        run_txn();
        head[1] = 16'h0100;
        pndng = 8'h02;
        run_txn();
        check_eq("drop_err", 32'(err_cnt), 32'h2);
        check_eq("drop_pkt", 32'(pkt_cnt), 32'h0);

        // Broadcast from port 3.
        do_reset();
        head[3] = 16'hFF3C;
        pndng = 8'h08;
        run_txn();

        // Reset during PUSH.
        do_reset();
        head[5] = 16'h0100;
        pndng = 8'h20;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("mid_push_pre", 32'(push), 32'h02);
        reset = 1'b0;
        #1;
        check_eq("mid_push", 32'(push), 32'h0);
        check_eq("mid_pop", 32'(pop), 32'h0);
        check_eq("mid_pkt", 32'(pkt_cnt), 32'h0);
        check_eq("mid_err", 32'(err_cnt), 32'h0);
        check_eq("mid_busy", 32'(busy), 32'h0);
        check_eq("mid_gnt", 32'(gnt_id), 32'h0);
        check_eq("mid_d_push", 32'(d_push), 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        m_ptr = 0;
        m_pkt = 0;
        m_err = 0;
        run_txn();
        check_eq("mid_regrant", 32'(gnt_id), 32'h5);

        // Randomized traffic.
        do_reset();
        for (int it = 0; it < 120; it++) begin
            for (int p = 0; p < N; p++) begin
                if (!pndng[p] && $urandom_range(0, 2) == 0) begin
                    head[p] = rand_head(p);
                    pndng[p] = 1'b1;
                end
            end
            run_txn();
        end

        // Error counter saturation via repeated loopback.
        do_reset();
        head[0] = 16'h0000;
        for (int it = 0; it < 260; it++) begin
            pndng = 8'h01;
            run_txn();
        end
        check_eq("err_sat", 32'(err_cnt), 32'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/bus_rr_arbiter_ctrl.md
# bus_rr_arbiter_ctrl

Round-robin arbiter and sequencer for the shared packet bus between `DRVRS` driver FIFOs. It watches each FIFO's `pndng` flag, grants one source at a time and pops its head word. It then decodes the destination ID from the packet's upper byte and pushes the word onto the shared `D_push` bus into the target port(s). It sits between the per-driver input FIFOs (pop side) and the per-driver output FIFOs (push side), replacing ad-hoc bus generation with a single scheduled controller.

## Interface
- `PCKG_SZ`, 16: packet width in bits; destination ID is `[PCKG_SZ-1 -: 8]`.
- `DRVRS`, 8: number of driver ports, 2..16.
- `BCAST_ID`, 8'hFF: destination ID meaning "all ports".
- `clk`  in  1  system clock, all state on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `pndng`  in  DRVRS  per-port "FIFO head valid"; held high until popped.
- `D_pop`  in  DRVRS*PCKG_SZ  per-port FIFO head words (first-word-fall-through), port i at `[i*PCKG_SZ +: PCKG_SZ]`.
- `pop`  out  DRVRS  one-hot pop strobe, one cycle.
- `push`  out  DRVRS  push strobe(s) to destination FIFOs.
- `D_push`  out  PCKG_SZ  shared bus word, valid while any `push` bit is high.
- `gnt_id`  out  $clog2(DRVRS)  index of current/last granted source.
- `busy`  out  1  high in POP and PUSH states.
- `pkt_cnt`  out  16  packets delivered (saturating).
- `err_cnt`  out  8  packets dropped for invalid destination (saturating).

## Operation
- FSM: IDLE -> POP -> PUSH -> IDLE; one packet per 3 cycles.
- IDLE: if `pndng != 0`, the winner is the first set bit at index >= `rr_ptr`, searching upward and wrapping modulo DRVRS. Register `gnt_id` and go to POP. Otherwise stay in IDLE.
- POP: `pop[gnt_id]=1` for exactly one cycle. Capture the `D_pop` slice of `gnt_id` into `data_q` at the closing edge. Set `rr_ptr = (gnt_id+1) mod DRVRS`.
- PUSH: `D_push = data_q` and `dest = data_q[PCKG_SZ-1 -: 8]`.
  - `dest < DRVRS` and `dest != gnt_id`: `push[dest]=1`; `pkt_cnt++`.
  - `dest == gnt_id`: no loopback, dropped; `err_cnt++`.
  - `dest >= DRVRS` and `dest != BCAST_ID`: dropped; `err_cnt++`.
  - `dest == BCAST_ID`: see Configuration.
  - In all cases the FSM returns to IDLE.
- `pndng` is ignored outside IDLE. A source deasserting `pndng` after grant is a FIFO contract violation; the captured word is still sent.
- Counters saturate: `pkt_cnt` at 16'hFFFF, `err_cnt` at 8'hFF; no wrap.

## Timing
- All outputs are registered; no combinational input-to-output path.
- `pndng` sampled high at edge t (IDLE): `pop` high in cycle t+1; `push` and `D_push` valid in cycle t+2; IDLE again at t+3.
- Back-to-back: continuous requests give a new `pop` every 3 cycles, rotating fairly. Each port waits at most 3*(DRVRS-1) cycles after the arbiter enters IDLE.
- `D_push` holds `data_q` outside PUSH; only `push` qualifies it.
- Reset (`reset=0`), asynchronous at any time including mid-packet:
  - State returns to IDLE; in-flight packet lost, no partial push.
  - `pop`, `push`, `D_push`, `gnt_id`, `busy`, `pkt_cnt`, `err_cnt`, `rr_ptr` all reset to 0.
  - First arbitration is on the first rising edge after `reset` deasserts.

## Configuration
- `BUS_BCAST_EN` defined: `dest == BCAST_ID` asserts `push` on every port except `gnt_id` in one PUSH cycle; `pkt_cnt` increments by 1.
- `BUS_BCAST_EN` undefined: broadcast packets are dropped and `err_cnt` increments. Broadcast logic is not synthesised.

## Test plan
- Single request: DRVRS=8, reset released, `pndng[2]=1`, head 16'h05AB -> `pop=8'h04` one cycle later, then `push=8'h20` with `D_push=16'h05AB`; `pkt_cnt=1`.
- Fairness: all 8 `pndng` held high for 24 cycles -> grant order 0,1,...,7, one `pop` per 3 cycles; each port popped exactly once.
- Wrap: last grant 7, then `pndng[0]` and `pndng[6]` high -> port 0 granted first, port 6 next.
- Invalid and loopback: head 16'h0A00 from port 1, then 16'h0100 from port 1 -> no `push` for either; `err_cnt=2`, `pkt_cnt=0`.
- Broadcast: head 16'hFF3C from port 3. With `BUS_BCAST_EN`: `push=8'hF7`, `D_push=16'hFF3C`. Without it: `push=0`, `err_cnt=1`.
- Reset mid-packet: assert `reset=0` during the PUSH cycle -> `push` drops to 0 immediately and all counters read 0. After release, a still-pending port is re-granted starting from port 0.
